// File: rtl/buffer_stream_reader_pkg.sv
// Shared sizing constants and the parameter legality check for the stream reader.
package buffer_stream_reader_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH          = 2**ADDR_WIDTH_DEF;
  localparam int CNT_W          = ADDR_WIDTH_DEF + 1;

  // A group must never straddle the wrap point, so DEPTH has to be a multiple
  // of both the write and read group sizes.
  function automatic bit par_ok(input int aw, input int pw, input int pr);
    int d;
    if (aw < 1 || aw > 30 || pw < 1 || pr < 1) return 1'b0;
    d = 1 << aw;
    return (pw <= d) && (pr <= d) && (d % pw == 0) && (d % pr == 0);
  endfunction

endpackage

// File: rtl/buffer_stream_reader_stream_out_reg.sv
// One-entry valid/ready output register: load wins over drain, data holds when drained.
module stream_out_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // Capture a new beat on load; otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/buffer_stream_reader.sv
// Read-side controller for the circular buffer: occupancy tracking, raddr,
// writer back-pressure and a registered valid/ready output stream.
module buffer_stream_reader
  import buffer_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 4,
  parameter int PAR_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           wr_commit,
  output logic                           wr_full,
  output logic [ADDR_WIDTH-1:0]          raddr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] buf_dout,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]            level,
  output logic                           overflow
);

  localparam int NW = 1 << ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  localparam int OW = PAR_READ * DATA_WIDTH;

  if (!par_ok(ADDR_WIDTH, PAR_WRITE, PAR_READ)) begin : g_bad_params
    $error("buffer_stream_reader: DEPTH must be a multiple of PAR_WRITE and PAR_READ");
  end

  localparam logic [LW-1:0]         DEPTH_C = LW'(NW);
  localparam logic [LW-1:0]         PW_C    = LW'(PAR_WRITE);
  localparam logic [LW-1:0]         PR_C    = LW'(PAR_READ);
  // Truncation to ADDR_WIDTH gives the natural mod-DEPTH pointer step.
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PAR_READ);

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]         free_words;
  logic [LW-1:0]         level_next;
  logic                  flush;
  logic                  pop;
  logic                  accept;

  assign flush      = rst | clear;
  assign raddr      = rd_ptr;
  assign free_words = DEPTH_C - level;
  assign wr_full    = free_words < PW_C;
  assign pop        = (level >= PR_C) && (!out_valid || out_ready);
  assign accept     = wr_commit && !wr_full;
  // Accept and pop may coincide; the sum never leaves 0..DEPTH.
  assign level_next = level + (accept ? PW_C : '0) - (pop ? PR_C : '0);

  // Pointer, occupancy and sticky overflow; rst/clear flush everything.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      level <= level_next;
      if (pop) rd_ptr <= rd_ptr + STEP_C;
      if (wr_commit && wr_full) overflow <= 1'b1;
    end
  end

  stream_out_reg #(.W(OW)) u_out (
    .clk   (clk),
    .flush (flush),
    .load  (pop),
    .din   (buf_dout),
    .ready (out_ready),
    .valid (out_valid),
    .data  (out_data)
  );

endmodule

// File: tb/tb_buffer_stream_reader.sv
// Directed bench for buffer_stream_reader with a behavioural model of the buffer.
module tb_buffer_stream_reader;

  logic        clk = 1'b0;
  logic        rst, clear, wr_commit, out_ready;
  logic        wr_full, out_valid, overflow;
  logic [3:0]  raddr;
  logic [15:0] buf_dout, out_data;
  logic [4:0]  level;

  logic [31:0] wgroup;
  logic [3:0]  waddr;
  logic [7:0]  mem [16];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  buffer_stream_reader #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .PAR_WRITE(4), .PAR_READ(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr_commit (wr_commit),
    .wr_full   (wr_full),
    .raddr     (raddr),
    .buf_dout  (buf_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  // Buffer model: combinational read of two words, parallel write of four.
  assign buf_dout = {mem[raddr + 4'd1], mem[raddr]};

  always @(posedge clk) begin
    if (rst || clear) begin
      waddr <= '0;
    end else if (wr_commit && !wr_full) begin
      for (int k = 0; k < 4; k++) mem[waddr + 4'(k)] <= wgroup[8*k +: 8];
      waddr <= waddr + 4'd4;
    end
  end

  function automatic logic [31:0] grp(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [31:0] beat(input logic [7:0] b);
    return 32'({b + 8'd1, b});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [7:0] wbase, e;
    int         left, nb, gaps;
    bit         started;

    rst = 1'b1; clear = 1'b0; wr_commit = 1'b0; out_ready = 1'b0; wgroup = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_level",    32'(level),     0);
    chk("rst_valid",    32'(out_valid), 0);
    chk("rst_raddr",    32'(raddr),     0);
    chk("rst_full",     32'(wr_full),   0);
    chk("rst_overflow", 32'(overflow),  0);
    chk("rst_data",     32'(out_data),  0);

    // 1. basic single commit, consumer always ready
    wr_commit = 1'b1; wgroup = 32'h13121110; out_ready = 1'b1;
    step();
    wr_commit = 1'b0;
    chk("t1_level_c0", 32'(level), 4);
    chk("t1_valid_c0", 32'(out_valid), 0);
    step();
    chk("t1_valid_c1", 32'(out_valid), 1);
    chk("t1_data0",    32'(out_data),  32'h1110);
    chk("t1_level_c1", 32'(level),     2);
    chk("t1_raddr_c1", 32'(raddr),     2);
    step();
    chk("t1_data1",    32'(out_data),  32'h1312);
    chk("t1_level_c2", 32'(level),     0);
    chk("t1_raddr_c2", 32'(raddr),     4);
    step();
    chk("t1_drained",  32'(out_valid), 0);
    chk("t1_hold",     32'(out_data),  32'h1312);

    // 2. fill with consumer stalled, then overflow
    do_clear();
    chk("t2_clr_level", 32'(level), 0);
    chk("t2_clr_raddr", 32'(raddr), 0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_commit = 1'b1; wgroup = grp(8'(8'h20 + 4*k));
      step();
      if (k == 2) begin
        chk("t2_level10", 32'(level),   10);
        chk("t2_notfull", 32'(wr_full), 0);
      end
    end
    wr_commit = 1'b0;
    chk("t2_level14", 32'(level),     14);
    chk("t2_full",    32'(wr_full),   1);
    chk("t2_valid",   32'(out_valid), 1);
    chk("t2_data",    32'(out_data),  32'h2120);
    chk("t2_no_ovf",  32'(overflow),  0);
    wr_commit = 1'b1; wgroup = grp(8'h30);
    step();
    wr_commit = 1'b0;
    chk("t2_ovf",       32'(overflow), 1);
    chk("t2_ovf_level", 32'(level),    14);
    chk("t2_ovf_data",  32'(out_data), 32'h2120);

    // 3. stream 40 words through the wrap point
    do_clear();
    chk("t3_clr_ovf",   32'(overflow), 0);
    chk("t3_clr_level", 32'(level),    0);
    out_ready = 1'b1; left = 10; wbase = 8'h40; e = 8'h40; nb = 0; gaps = 0; started = 1'b0;
    for (int cyc = 0; cyc < 200 && nb < 20; cyc++) begin
      if (left > 0 && !wr_full) begin
        wr_commit = 1'b1; wgroup = grp(wbase); wbase = wbase + 8'd4; left--;
      end else begin
        wr_commit = 1'b0;
      end
      if (out_valid) begin
        chk("t3_data",  32'(out_data), beat(e));
        chk("t3_raddr", 32'(raddr),    32'(((nb + 1) * 2) % 16));
        e = e + 8'd2; nb++; started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      step();
    end
    wr_commit = 1'b0;
    chk("t3_beats", 32'(nb),   20);
    chk("t3_gaps",  32'(gaps), 0);

    // 4. back-pressure: ready toggles every cycle
    do_clear();
    left = 4; wbase = 8'h80; e = 8'h80; nb = 0;
    for (int cyc = 0; cyc < 100 && nb < 8; cyc++) begin
      out_ready = cyc[0];
      if (left > 0 && !wr_full) begin
        wr_commit = 1'b1; wgroup = grp(wbase); wbase = wbase + 8'd4; left--;
      end else begin
        wr_commit = 1'b0;
      end
      if (out_valid) begin
        chk("t4_data", 32'(out_data), beat(e));
        if (out_ready) begin
          e = e + 8'd2; nb++;
        end
      end
      step();
    end
    wr_commit = 1'b0; out_ready = 1'b0;
    chk("t4_beats", 32'(nb),        8);
    chk("t4_empty", 32'(out_valid), 0);
    chk("t4_level", 32'(level),     0);

    // 5. simultaneous accept and pop at level 2 with a held beat
    do_clear();
    wr_commit = 1'b1; wgroup = grp(8'h50);
    step();
    wr_commit = 1'b0;
    step();
    chk("t5_pre_level", 32'(level),     2);
    chk("t5_pre_valid", 32'(out_valid), 1);
    chk("t5_pre_data",  32'(out_data),  32'h5150);
    wr_commit = 1'b1; wgroup = grp(8'h60); out_ready = 1'b1;
    step();
    wr_commit = 1'b0; out_ready = 1'b0;
    chk("t5_level", 32'(level),     4);
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_data",  32'(out_data),  32'h5352);
    chk("t5_raddr", 32'(raddr),     4);

    // 6. reset mid-stream at level 6, other inputs active during rst
    do_clear();
    wr_commit = 1'b1; wgroup = grp(8'h70);
    step();
    wgroup = grp(8'h74);
    step();
    wr_commit = 1'b0;
    chk("t6_pre_level", 32'(level),     6);
    chk("t6_pre_valid", 32'(out_valid), 1);
    rst = 1'b1; wr_commit = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; wr_commit = 1'b0; out_ready = 1'b0;
    chk("t6_level",    32'(level),     0);
    chk("t6_valid",    32'(out_valid), 0);
    chk("t6_raddr",    32'(raddr),     0);
    chk("t6_overflow", 32'(overflow),  0);
    chk("t6_full",     32'(wr_full),   0);
    step();
    chk("t6_no_beat",  32'(out_valid), 0);
    chk("t6_level2",   32'(level),     0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
